div_mae_monitor: RTL

Sequential error monitor that sits directly downstream of the approximate 16/8 array divider. It captures each operand pair together with the approximate quotient and remainder the divider produced. It recomputes the exact result with an 8-step restoring divider and accumulates running error statistics: summed absolute quotient error (for MAE), maximum error, sample count and remainder-mismatch count. These statistics are used to characterise candidate approximate cells in hardware.

---
 rtl/div_mae_monitor.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/div_mae_monitor.sv
`default_nettype none
// ============================================================================
// div_mae_monitor - recomputes exact 16/8 quotients and gathers error stats
// Revision 1.0
// ============================================================================
module div_mae_monitor #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      n,
  input  logic [7:0]       d,
  input  logic [7:0]       q_apx,
  input  logic [7:0]       r_apx,
  input  logic             clear,
  output logic             sample_done,
  output logic [7:0]       q_exact,
  output logic [CNT_W-1:0] err_sum,
  output logic [7:0]       err_max,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] rem_mis_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    ACC  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t       state;
  state_t       state_nxt;
  logic [7:0]   d_r;
  logic [7:0]   q_apx_r;
  logic [7:0]   r_apx_r;
  logic         sat_r;
  logic [8:0]   rem;
  logic [7:0]   lo;
  logic [7:0]   quo;
  logic [2:0]   step;

  logic         sat_in;
  logic [8:0]   t;
  logic         t_ge;
  logic [8:0]   rem_nxt;
  logic [7:0]   err;
  logic [CNT_W:0] sum_ext;

  assign in_ready = (state == IDLE);
  assign sat_in   = (d == 8'd0) || (n[15:8] >= d);

  // Restoring step: rem < d always holds, so t < 2d and one subtract suffices
  assign t       = {rem[7:0], lo[7]};
  assign t_ge    = (t >= {1'b0, d_r});
  assign rem_nxt = t_ge ? (t - {1'b0, d_r}) : t;

  assign err     = (q_apx_r >= quo) ? (q_apx_r - quo) : (quo - q_apx_r);
  assign sum_ext = {1'b0, err_sum} + {{(CNT_W + 1 - 8){1'b0}}, err};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = sat_in ? ACC : DIV;
      DIV:     if (step == 3'd0) state_nxt = ACC;
      ACC:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_r         <= '0;
      q_apx_r     <= '0;
      r_apx_r     <= '0;
      sat_r       <= 1'b0;
      rem         <= '0;
      lo          <= '0;
      quo         <= '0;
      step        <= '0;
      sample_done <= 1'b0;
      q_exact     <= '0;
      err_sum     <= '0;
      err_max     <= '0;
      sample_cnt  <= '0;
      rem_mis_cnt <= '0;
    end else begin
      sample_done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            d_r     <= d;
            q_apx_r <= q_apx;
            r_apx_r <= r_apx;
            sat_r   <= sat_in;
            if (sat_in) begin
              quo <= 8'hFF;
            end else begin
              rem  <= {1'b0, n[15:8]};
              lo   <= n[7:0];
              step <= 3'd7;
            end
          end
        end
        DIV: begin
          rem  <= rem_nxt;
          lo   <= {lo[6:0], 1'b0};
          quo  <= {quo[6:0], t_ge};
          step <= step - 3'd1;
        end
        ACC: begin
          sample_done <= 1'b1;
          q_exact     <= quo;
          if (!clear) begin
            err_sum    <= sum_ext[CNT_W] ? '1 : sum_ext[CNT_W-1:0];
            err_max    <= (err > err_max) ? err : err_max;
            sample_cnt <= (&sample_cnt) ? sample_cnt : sample_cnt + CNT_ONE;
            if (!sat_r && (rem != {1'b0, r_apx_r}) && !(&rem_mis_cnt))
              rem_mis_cnt <= rem_mis_cnt + CNT_ONE;
          end
        end
        default: ;
      endcase
      // Placed last so a clear landing in ACC discards that sample's contribution
      if (clear) begin
        err_sum     <= '0;
        err_max     <= '0;
        sample_cnt  <= '0;
        rem_mis_cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire
